// File: rtl/reg_enable_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_enable_sequencer_if
// Purpose  : Byte-strobe / register-enable bundle between PS/2 receiver,
//            sequencer and capture-register consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_enable_sequencer_if #(
    parameter int NUM_REGS = 4
);
    localparam int SW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                byte_valid;
    logic                frame_ack;
    logic [NUM_REGS-1:0] reg_en;
    logic [SW-1:0]       slot;
    logic                active;
    logic                frame_done;
    logic                timeout;
    logic                overrun;

    modport master (
        output byte_valid,
        output frame_ack,
        input  reg_en,
        input  slot,
        input  active,
        input  frame_done,
        input  timeout,
        input  overrun
    );

    modport slave (
        input  byte_valid,
        input  frame_ack,
        output reg_en,
        output slot,
        output active,
        output frame_done,
        output timeout,
        output overrun
    );
endinterface
`default_nettype wire

// File: rtl/reg_enable_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_enable_sequencer
// Purpose  : Counts PS/2 byte strobes into NUM_REGS one-hot register enables,
//            holds the completed frame until acknowledged, aborts on timeout.
// Revision : 1.0 - initial release
// ============================================================================
module reg_enable_sequencer #(
    parameter int NUM_REGS       = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    reg_enable_sequencer_if.slave  bus
);
    localparam int SW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;

    localparam bit                  TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam bit                  SINGLE    = (NUM_REGS == 1);
    localparam logic [TW-1:0]       TMR_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [SW-1:0]       SLOT_LAST = SW'(NUM_REGS - 1);
    localparam logic [SW-1:0]       SLOT_ONE  = SW'(1);
    localparam logic [NUM_REGS-1:0] EN_FIRST  = NUM_REGS'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
    logic                active_q, active_d;
    logic                frame_done_q, frame_done_d;
    logic                timeout_q, timeout_d;
    logic                overrun_q, overrun_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            timer_q      <= '0;
            reg_en_q     <= '0;
            active_q     <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            timer_q      <= timer_d;
            reg_en_q     <= reg_en_d;
            active_q     <= active_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        timer_d      = timer_q;
        reg_en_d     = '0;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.byte_valid) begin
                    reg_en_d = EN_FIRST;
                    if (SINGLE) begin
                        frame_done_d = 1'b1;
                        slot_d       = '0;
                        state_d      = DONE;
                    end else begin
                        slot_d  = SLOT_ONE;
                        timer_d = '0;
                        state_d = COLLECT;
                    end
                end
            end

            COLLECT: begin
                if (bus.byte_valid) begin
                    // A byte arriving on the expiry cycle still belongs to the frame.
                    reg_en_d = EN_FIRST << slot_q;
                    timer_d  = '0;
                    if (slot_q == SLOT_LAST) begin
                        frame_done_d = 1'b1;
                        slot_d       = '0;
                        state_d      = DONE;
                    end else begin
                        slot_d = slot_q + SLOT_ONE;
                    end
                end else if (TO_EN) begin
                    if (timer_q == TMR_LAST) begin
                        timeout_d = 1'b1;
                        slot_d    = '0;
                        timer_d   = '0;
                        state_d   = IDLE;
                    end else if (timer_q != '1) begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end

            DONE: begin
                if (bus.frame_ack) begin
                    overrun_d = 1'b0;
                    if (bus.byte_valid) begin
                        // Ack and byte together: the byte opens the next frame.
                        reg_en_d = EN_FIRST;
                        if (SINGLE) begin
                            frame_done_d = 1'b1;
                            slot_d       = '0;
                            state_d      = DONE;
                        end else begin
                            slot_d  = SLOT_ONE;
                            timer_d = '0;
                            state_d = COLLECT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.byte_valid) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                slot_d  = '0;
                timer_d = '0;
            end
        endcase

        active_d = (state_d == DONE);
    end

    assign bus.reg_en     = reg_en_q;
    assign bus.slot       = slot_q;
    assign bus.active     = active_q;
    assign bus.frame_done = frame_done_q;
    assign bus.timeout    = timeout_q;
    assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: doc/reg_enable_sequencer.md
Name: reg_enable_sequencer

Overview:
- Parametrised successor to the PS/2 register-enable decoder.
- Instead of decoding an external state code, it runs its own FSM. The FSM counts byte-valid strobes from the PS/2 receiver and issues a one-cycle one-hot write enable to each of NUM_REGS capture registers in turn.
- Once all slots are written it holds `active` until the consumer acknowledges.
- Adds an inter-byte timeout abort and overrun detection.

Parameters:
- NUM_REGS, 4, number of capture registers / bytes per frame; legal 1..16.
- TIMEOUT_CYCLES, 50000, max clk cycles allowed between bytes inside a frame; 0 disables timeout.
- SW, derived = max(1, clog2(NUM_REGS)), slot index width; not user-set.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- byte_valid  in  1  single-cycle strobe: receiver has a new byte.
- frame_ack  in  1  consumer has read the frame; level-sampled, only meaningful in DONE.
- reg_en  out  NUM_REGS  one-hot, one-cycle write enable for capture register [slot].
- slot  out  SW  index of the next register to be written.
- active  out  1  high while a complete frame is held (state DONE).
- frame_done  out  1  one-cycle pulse coincident with the last reg_en of a frame.
- timeout  out  1  one-cycle pulse when a partial frame is aborted.
- overrun  out  1  sticky: a byte arrived while in DONE and was dropped.

Behaviour:
- All outputs registered. A byte_valid sampled at edge k produces its reg_en bit high for exactly the cycle after edge k; latency 1.
- Reset (rst=0, async): state=IDLE, slot=0, timer=0, reg_en=0, active=0, frame_done=0, timeout=0, overrun=0. Releasing reset mid-frame discards the partial frame.
- States: IDLE, COLLECT, DONE.
- IDLE, on byte_valid:
  - reg_en[0] pulses.
  - If NUM_REGS==1: frame_done pulses and the FSM goes to DONE; slot stays 0.
  - Else: slot←1, timer←0, go to COLLECT.
- IDLE: frame_ack is ignored.
- COLLECT, on byte_valid:
  - reg_en[slot] pulses and timer←0.
  - If slot==NUM_REGS-1: frame_done pulses, slot←0, go to DONE.
  - Else: slot←slot+1.
- COLLECT, no byte_valid and TIMEOUT_CYCLES≠0:
  - timer increments each cycle.
  - When timer reaches TIMEOUT_CYCLES-1: timeout pulses, slot←0, timer←0, go to IDLE. No reg_en is issued.
  - byte_valid on the same cycle as expiry wins: the byte is written and the timer resets.
- DONE:
  - active=1 for the whole state (registered, so it rises with the cycle frame_done is high).
  - byte_valid without frame_ack: byte dropped, overrun←1, no reg_en.
- DONE, on frame_ack:
  - active←0 and overrun←0.
  - Without byte_valid: go to IDLE.
  - With byte_valid on the same cycle: the byte is the first of a new frame. reg_en[0] pulses, slot←1, go to COLLECT (NUM_REGS==1: frame_done pulses and the FSM stays in DONE with active re-asserted). overrun is not set.
- reg_en is never multi-hot. reg_en, frame_done and timeout are never high for two consecutive cycles without a new byte_valid.
- Timer width: clog2(TIMEOUT_CYCLES)+1; saturates, never wraps.
- slot wraps only via the explicit return to 0. Values ≥NUM_REGS are unreachable.

Test Plan:
- Bench setup: NUM_REGS=4, TIMEOUT_CYCLES=16 unless stated.
- Reset, then four byte_valid pulses 3 cycles apart:
  - reg_en = 0001, 0010, 0100, 1000, each one cycle after its strobe.
  - frame_done high with 1000.
  - active=1 from that cycle; slot reads 0,1,2,3 then 0.
- After a full frame, two more byte_valid then frame_ack:
  - no reg_en for the extra bytes; overrun=1 after the first.
  - After ack: active=0, overrun=0, state IDLE.
- Two bytes, then idle:
  - after 16 idle cycles, timeout pulses once; slot=0, no active.
  - the next byte yields reg_en=0001.
- In DONE, frame_ack and byte_valid on the same cycle:
  - next cycle reg_en=0001, active=0, overrun=0, slot=1.
- Assert rst low asynchronously mid-edge with slot=2:
  - all outputs 0 immediately.
  - after release, the first byte gives reg_en=0001.
- Second bench with NUM_REGS=1, TIMEOUT_CYCLES=0:
  - each byte with ack gives reg_en=1 and frame_done together; active toggles accordingly.
  - no timeout ever, even after 10000 idle cycles.
